// File: rtl/adf4360_pkg.sv
// ADF4360 programming-interface constants shared by the
// programmer and the board-side monitor.
package adf4360_pkg;

  localparam int WORD_W = 24;
  localparam int CNT_W  = 5;
  localparam int GAP_W  = 16;

  localparam logic [1:0] ADDR_C = 2'b00;
  localparam logic [1:0] ADDR_R = 2'b01;
  localparam logic [1:0] ADDR_N = 2'b10;
  localparam logic [1:0] ADDR_X = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX  = 5'd31;
  localparam logic [CNT_W-1:0] CNT_WORD = 5'd24;
  localparam logic [GAP_W-1:0] GAP_MAX  = 16'hFFFF;

  localparam int ERR_LEN  = 0;
  localparam int ERR_ADDR = 1;
  localparam int ERR_GAP  = 2;

  typedef enum logic [1:0] {
    EXP_R = 2'b00,
    EXP_C = 2'b01,
    EXP_N = 2'b10
  } seq_state_t;

endpackage

// File: rtl/adf4360_spi_monitor_sync_edge.sv
// Multi-flop synchroniser with a delay flop for
// rising-edge detection on one asynchronous pin.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Reset to the pin's idle level so release
  // does not fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;

endmodule

// File: rtl/adf4360_spi_monitor.sv
// Board-side ADF4360 3-wire receiver: deserialises,
// files R/C/N words and flags length/address/gap faults.
module adf4360_spi_monitor
  import adf4360_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_GAP     = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sclk_i,
  input  logic              sdata_i,
  input  logic              le_i,
  output logic [WORD_W-1:0] r_o,
  output logic [WORD_W-1:0] c_o,
  output logic [WORD_W-1:0] n_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic              seq_done_o,
  output logic [2:0]        err_o,
  output logic              err_pulse_o
);

  localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);

  logic sclk_lvl;
  logic sclk_rise;
  logic sdata_lvl;
  logic sdata_rise_unused;
  logic le_lvl;
  logic le_rise;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_sclk (
    .clk  (clk_i),
    .rst_n(rst_n_i),
    .din  (sclk_i),
    .level(sclk_lvl),
    .rise (sclk_rise)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_sdata (
    .clk  (clk_i),
    .rst_n(rst_n_i),
    .din  (sdata_i),
    .level(sdata_lvl),
    .rise (sdata_rise_unused)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_le (
    .clk  (clk_i),
    .rst_n(rst_n_i),
    .din  (le_i),
    .level(le_lvl),
    .rise (le_rise)
  );

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_nx;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nx;
  logic [GAP_W-1:0]  gap_q;
  seq_state_t        state_q;
  seq_state_t        state_d;

  logic       shift_en;
  logic       len_ok;
  logic [1:0] addr;
  logic       len_err;
  logic       addr_err;
  logic       gap_err;
  logic       good;
  logic       is_r;
  logic       is_c;
  logic       is_n;
  logic       seq_done_d;

  // A bit arriving with the le edge is shifted
  // before the latch is judged.
  always_comb begin
    shift_en = sclk_rise & (~le_lvl | le_rise);
    shift_nx = shift_q;
    cnt_nx   = cnt_q;
    if (shift_en) begin
      shift_nx = {shift_q[WORD_W-2:0], sdata_lvl};
      if (cnt_q != CNT_MAX) begin
        cnt_nx = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    len_ok   = (cnt_nx == CNT_WORD);
    addr     = shift_nx[1:0];
    len_err  = le_rise & ~len_ok;
    addr_err = le_rise & len_ok & (addr == ADDR_X);
    good     = le_rise & len_ok & (addr != ADDR_X);
    is_r     = good & (addr == ADDR_R);
    is_c     = good & (addr == ADDR_C);
    is_n     = good & (addr == ADDR_N);
    gap_err  = is_n & (state_q == EXP_N) &
               (gap_q < MIN_GAP_V);
  end

  always_comb begin
    state_d    = state_q;
    seq_done_d = 1'b0;
    unique case (1'b1)
      len_err, addr_err: begin
        state_d = EXP_R;
      end
      is_r: begin
        state_d = EXP_C;
      end
      is_c: begin
        state_d = (state_q == EXP_C) ? EXP_N : EXP_R;
      end
      is_n: begin
        state_d    = EXP_R;
        seq_done_d = (state_q == EXP_N);
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EXP_R;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_nx;
      cnt_q   <= le_rise ? '0 : cnt_nx;
      if (is_c) begin
        gap_q <= '0;
      end else if (gap_q != GAP_MAX) begin
        gap_q <= gap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_o          <= '0;
      c_o          <= '0;
      n_o          <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      seq_done_o   <= 1'b0;
      err_o        <= '0;
      err_pulse_o  <= 1'b0;
    end else begin
      word_valid_o <= good;
      seq_done_o   <= seq_done_d;
      err_pulse_o  <= len_err | addr_err | gap_err;
      err_o[ERR_LEN]  <= err_o[ERR_LEN] | len_err;
      err_o[ERR_ADDR] <= err_o[ERR_ADDR] | addr_err;
      err_o[ERR_GAP]  <= err_o[ERR_GAP] | gap_err;
      if (good) begin
        word_o <= shift_nx;
      end
      if (is_r) begin
        r_o <= shift_nx;
      end
      if (is_c) begin
        c_o <= shift_nx;
      end
      if (is_n) begin
        n_o <= shift_nx;
      end
    end
  end

endmodule

// File: tb/tb_adf4360_spi_monitor.sv
// Directed bench for adf4360_spi_monitor: drives the
// three-wire pins from negedge, checks on negedge.
module tb_adf4360_spi_monitor;

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        sdata;
  logic        le;
  logic [23:0] r_o;
  logic [23:0] c_o;
  logic [23:0] n_o;
  logic [23:0] word_o;
  logic        word_valid;
  logic        seq_done;
  logic [2:0]  err;
  logic        err_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int wv_cnt  = 0;
  int sd_cnt  = 0;
  int ep_cnt  = 0;
  int wv0, sd0, ep0;

  // Shifting a whole word takes far more than 5 cycles,
  // so a larger threshold makes the short-gap case reachable.
  adf4360_spi_monitor #(
    .SYNC_STAGES(2),
    .MIN_GAP    (80)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sclk_i      (sclk),
    .sdata_i     (sdata),
    .le_i        (le),
    .r_o         (r_o),
    .c_o         (c_o),
    .n_o         (n_o),
    .word_o      (word_o),
    .word_valid_o(word_valid),
    .seq_done_o  (seq_done),
    .err_o       (err),
    .err_pulse_o (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid) wv_cnt++;
    if (seq_done)   sd_cnt++;
    if (err_pulse)  ep_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    wv0 = wv_cnt;
    sd0 = sd_cnt;
    ep0 = ep_cnt;
  endtask

  task automatic send_bits(input logic [31:0] w,
                           input int n, input int ph);
    for (int i = n - 1; i >= 0; i--) begin
      sclk  = 1'b0;
      sdata = w[i];
      repeat (ph) @(negedge clk);
      sclk = 1'b1;
      repeat (ph) @(negedge clk);
    end
  endtask

  task automatic latch();
    le = 1'b1;
    repeat (4) @(negedge clk);
    le = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits({8'h0, w}, 24, 4);
    latch();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b1;
    sdata = 1'b0;
    le    = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state and idle quiet
    check("rst_r", r_o, 0);
    check("rst_c", c_o, 0);
    check("rst_n", n_o, 0);
    check("rst_word", word_o, 0);
    check("rst_err", err, 0);
    snap();
    repeat (100) @(negedge clk);
    check("idle_wv", wv_cnt - wv0, 0);
    check("idle_sd", sd_cnt - sd0, 0);
    check("idle_ep", ep_cnt - ep0, 0);

    // R with latency check, then C, N
    snap();
    send_bits(32'h000141, 24, 4);
    le = 1'b1;
    @(negedge clk);
    check("lat_e1", word_valid, 0);
    @(negedge clk);
    check("lat_e2", word_valid, 0);
    @(negedge clk);
    check("lat_e3", word_valid, 1);
    check("lat_r", r_o, 32'h000141);
    @(negedge clk);
    check("lat_e4", word_valid, 0);
    le = 1'b0;
    repeat (14) @(negedge clk);
    send_word(24'h4FF128);
    send_word(24'h003202);
    check("seq_r", r_o, 32'h000141);
    check("seq_c", c_o, 32'h4FF128);
    check("seq_n", n_o, 32'h003202);
    check("seq_word", word_o, 32'h003202);
    check("seq_wv", wv_cnt - wv0, 3);
    check("seq_sd", sd_cnt - sd0, 1);
    check("seq_err", err, 0);
    check("seq_ep", ep_cnt - ep0, 0);

    // 23-bit and 25-bit words
    snap();
    send_bits(32'h000155, 23, 4);
    latch();
    check("len23_err", err, 3'b001);
    send_bits(32'h1000155, 25, 4);
    latch();
    check("len_err", err, 3'b001);
    check("len_ep", ep_cnt - ep0, 2);
    check("len_wv", wv_cnt - wv0, 0);
    check("len_r", r_o, 32'h000141);
    check("len_word", word_o, 32'h003202);
    send_word(24'h000185);
    check("len_next_r", r_o, 32'h000185);
    check("len_next_wv", wv_cnt - wv0, 1);

    // address 11
    snap();
    send_word(24'hABCDE3);
    check("addr_err", err, 3'b011);
    check("addr_ep", ep_cnt - ep0, 1);
    check("addr_wv", wv_cnt - wv0, 0);
    check("addr_word", word_o, 32'h000185);

    // C followed by a fast N
    snap();
    send_word(24'h000141);
    send_bits(32'h4FF128, 24, 4);
    latch();
    send_bits(32'h003206, 24, 1);
    latch();
    check("gap_err", err, 3'b111);
    check("gap_n", n_o, 32'h003206);
    check("gap_sd", sd_cnt - sd0, 1);
    check("gap_ep", ep_cnt - ep0, 1);
    check("gap_wv", wv_cnt - wv0, 3);

    // reset part-way through a word
    send_bits(32'h000ABC, 12, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_err", err, 0);
    check("mid_rst_n", n_o, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_r", r_o, 0);
    check("mid_rst_word", word_o, 0);
    snap();
    send_word(24'h012345);
    check("post_rst_r", r_o, 32'h012345);
    check("post_rst_c", c_o, 0);
    check("post_rst_err", err, 0);
    check("post_rst_wv", wv_cnt - wv0, 1);
    check("post_rst_ep", ep_cnt - ep0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
